// File: rtl/booth_multiplier.sv
// ---------------------------------------------------------------------------
// booth_multiplier
//
// Sequential signed radix-2 Booth multiplier. Two two's-complement operands
// are captured on a start strobe while idle. One Booth recoding step then
// runs per clock, and the full-precision 2*WIDTH-bit signed product is
// registered together with a one-cycle done pulse.
//
// Latency : WIDTH cycles from the capture edge to a valid product.
// Rate    : one result every WIDTH+1 cycles when start is held high.
//
// Ports
//   clk      in   1        rising-edge clock
//   rst_n    in   1        asynchronous active-low reset
//   i_start  in   1        request, sampled only while o_busy = 0
//   i_a      in   WIDTH    signed multiplicand
//   i_b      in   WIDTH    signed multiplier
//   o_p      out  2*WIDTH  signed product, held until the next completion
//   o_busy   out  1        multiplication in progress
//   o_done   out  1        one-cycle pulse on the cycle o_p is updated
//
// FSM states
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | waiting for i_start; operands are loaded on leaving
//   ST_RUN  | one Booth step per clock until the step counter ends
// ---------------------------------------------------------------------------
module booth_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_p,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH:0]     r_m;
    logic [WIDTH:0]     r_acc;
    logic [WIDTH-1:0]   r_q;
    logic               r_q1;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_p;
    logic               r_done;

    logic               w_load;
    logic               w_step;
    logic               w_last;

    logic [WIDTH:0]     w_acc_sum;
    logic [2*WIDTH+1:0] w_shift;
    logic [WIDTH:0]     w_acc_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_q1_nxt;

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                // Counter holds the number of steps still to run, so the
                // step taken while it reads 1 is the final one.
                if (r_count == CW'(1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Booth step datapath
    // -----------------------------------------------------------------------
    always_comb begin
        w_acc_sum = r_acc;
        case ({r_q[0], r_q1})
            2'b01:   w_acc_sum = r_acc + r_m;
            2'b10:   w_acc_sum = r_acc - r_m;
            default: w_acc_sum = r_acc;
        endcase
    end

    // Arithmetic right shift of {ACC, Q, Q_1}: the ACC sign bit is replicated
    // at the top and the old Q[0] drops into Q_1.
    assign w_shift   = {w_acc_sum[WIDTH], w_acc_sum, r_q};
    assign w_acc_nxt = w_shift[2*WIDTH+1:WIDTH+1];
    assign w_q_nxt   = w_shift[WIDTH:1];
    assign w_q1_nxt  = w_shift[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_count <= '0;
        end else if (w_load) begin
            // One guard bit on M and ACC keeps -2^(WIDTH-1) subtractions exact.
            r_m     <= {i_a[WIDTH-1], i_a};
            r_acc   <= '0;
            r_q     <= i_b;
            r_q1    <= 1'b0;
            r_count <= CW'(WIDTH);
        end else if (w_step) begin
            r_acc   <= w_acc_nxt;
            r_q     <= w_q_nxt;
            r_q1    <= w_q1_nxt;
            r_count <= r_count - CW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Result and status
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                // The guard bit of ACC is dropped; the low 2*WIDTH bits
                // already carry the correctly signed product.
                r_p <= {w_acc_nxt[WIDTH-1:0], w_q_nxt};
            end
        end
    end

    assign o_p    = r_p;
    assign o_busy = (r_state == ST_RUN);
    assign o_done = r_done;

endmodule

// File: tb/tb_booth_multiplier.sv
// ---------------------------------------------------------------------------
// tb_booth_multiplier
//
// Self-checking bench for booth_multiplier at WIDTH = 4. Expected products
// come from plain integer multiplication of the sign-extended operands.
// ---------------------------------------------------------------------------
module tb_booth_multiplier;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           i_start;
    logic [W-1:0]   i_a;
    logic [W-1:0]   i_b;
    logic [2*W-1:0] o_p;
    logic           o_busy;
    logic           o_done;

    int n_checks = 0;
    int n_pass   = 0;

    booth_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_p     (o_p),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: signed product truncated to 2*W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia;
        int ib;
        int prod;
        ia   = int'($signed(a));
        ib   = int'($signed(b));
        prod = ia * ib;
        return prod[2*W-1:0];
    endfunction

    // One complete operation started from idle; checks latency, product,
    // that p holds its old value while running, and that done is one cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int g;
        int cyc;
        logic [2*W-1:0] prev_p;
        logic [2*W-1:0] exp;
        g = 0;
        while (o_busy && g < 50) begin
            @(posedge clk); #1; g++;
        end
        exp    = ref_mul(a, b);
        prev_p = o_p;
        @(negedge clk);
        i_a = a; i_b = b; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_a = W'($urandom);
        i_b = W'($urandom);
        cyc = 0;
        while (!o_done && cyc < 20) begin
            if (o_p !== prev_p) chk({tag, "_hold"}, 32'(o_p), 32'(prev_p));
            @(posedge clk); #1; cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(W));
        chk({tag, "_p"}, 32'(o_p), 32'(exp));
        @(posedge clk); #1;
        chk({tag, "_done1cyc"}, 32'(o_done), 32'd0);
    endtask

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; } pair_t;

    initial begin
        pair_t dir[$];
        pair_t hs[$];
        int    cnt;
        logic  seen_done;

        i_start = 1'b0; i_a = '0; i_b = '0;
        rst_n   = 1'b0;
        #12;
        chk("rst_p",    32'(o_p),    32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed positives and signed/extreme cases.
        dir = '{'{4'd2,4'd2}, '{4'd3,4'd2}, '{4'd3,4'd4}, '{4'd1,4'd4},
                '{4'd0,4'd4}, '{4'd5,4'd4}, '{4'd6,4'd4},
                '{4'hD,4'd5}, '{4'h8,4'd7}, '{4'h8,4'h8}, '{4'd7,4'h8},
                '{4'hF,4'hF}, '{4'd7,4'd7}};
        foreach (dir[i]) run_op(dir[i].a, dir[i].b, $sformatf("dir%0d", i));

        // Handshake: start held high, operands scrambled while busy.
        hs = '{'{4'd3,4'hE}, '{4'h8,4'h8}, '{4'd5,4'd5}, '{4'hB,4'd6}};
        @(negedge clk);
        i_start = 1'b1;
        foreach (hs[k]) begin
            i_a = hs[k].a; i_b = hs[k].b;
            @(posedge clk); #1;
            chk($sformatf("hs%0d_busy", k), 32'(o_busy), 32'd1);
            for (int s = 1; s <= W; s++) begin
                @(negedge clk);
                i_a = W'($urandom); i_b = W'($urandom);
                @(posedge clk); #1;
                if (s < W) chk($sformatf("hs%0d_nodone%0d", k, s), 32'(o_done), 32'd0);
            end
            chk($sformatf("hs%0d_done", k), 32'(o_done), 32'd1);
            chk($sformatf("hs%0d_idle", k), 32'(o_busy), 32'd0);
            chk($sformatf("hs%0d_p", k), 32'(o_p), 32'(ref_mul(hs[k].a, hs[k].b)));
            @(negedge clk);
        end
        i_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Abort: reset asserted between edges two cycles into (4,4).
        run_op(4'd3, 4'd3, "pre_abort");
        @(negedge clk);
        i_a = 4'd4; i_b = 4'd4; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_p",    32'(o_p),    32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        seen_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            seen_done |= o_done;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            seen_done |= o_done;
        end
        chk("abort_nodone", 32'(seen_done), 32'd0);
        chk("abort_p_after", 32'(o_p), 32'd0);
        run_op(4'd4, 4'd4, "post_abort");

        // Exhaustive sweep of all signed 4-bit pairs.
        cnt = 0;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run_op(W'(x), W'(y), $sformatf("sw_%0d_%0d", x, y));
                cnt++;
            end
        end
        chk("sweep_count", 32'(cnt), 32'd256);

        // A few random operations to finish.
        for (int r = 0; r < 20; r++) begin
            run_op(W'($urandom), W'($urandom), $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
